// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for a five-stage in-order pipeline.
// Tracks the writers sitting in EX, MEM and WB, decides stall/flush for the
// instruction in ID, registers the operand-forwarding selects for the
// instruction entering EX, and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // One tracked pipeline slot: who writes which register, and whether the
    // value only becomes available after the memory access.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memread;
    } entry_t;

    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_EX_MEM = 2'b01;
    localparam logic [1:0] SEL_MEM_WB = 2'b10;
    localparam logic [1:0] SEL_WB_CAP = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    entry_t     ex_q;
    entry_t     mem_q;
    entry_t     wb_q;
    entry_t     ex_d;

    logic       rs_ex;
    logic       rs_mem;
    logic       rs_wb;
    logic       rt_ex;
    logic       rt_mem;
    logic       rt_wb;
    logic       hz;
    logic       issue;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;

    // The memread flag of the older slots is carried along with the entry
    // but only the EX slot's copy drives a decision.
    logic       unused_memread;
    assign unused_memread = mem_q.memread ^ wb_q.memread;

    // A source depends on a slot only if it is really read, the slot really
    // writes it, and it is not the hard-wired zero register.
    function automatic logic src_match(input entry_t           e,
                                       input logic             use_bit,
                                       input logic [REG_AW-1:0] src);
        return use_bit && e.valid && e.regwrite &&
               (e.dest == src) && (src != '0);
    endfunction

    // The youngest producer wins, since it holds the newest value.
    function automatic logic [1:0] fwd_code(input logic hit_ex,
                                            input logic hit_mem,
                                            input logic hit_wb);
        logic [1:0] code;
        code = SEL_RF;
        if (hit_ex) begin
            code = SEL_EX_MEM;
        end else if (hit_mem) begin
            code = SEL_MEM_WB;
        end else if (hit_wb) begin
            code = SEL_WB_CAP;
        end
        return code;
    endfunction

    // Compare both sources of the ID instruction against every tracked slot.
    always_comb begin
        rs_ex  = src_match(ex_q,  id_use_rs, id_rs);
        rs_mem = src_match(mem_q, id_use_rs, id_rs);
        rs_wb  = src_match(wb_q,  id_use_rs, id_rs);
        rt_ex  = src_match(ex_q,  id_use_rt, id_rt);
        rt_mem = src_match(mem_q, id_use_rt, id_rt);
        rt_wb  = src_match(wb_q,  id_use_rt, id_rt);
    end

    // With forwarding only a load still in EX is too late; without it any
    // in-flight writer of a source blocks the instruction.
    always_comb begin
        hz = 1'b0;
        if (FWD_EN != 0) begin
            hz = (rs_ex || rt_ex) && ex_q.memread;
        end else begin
            hz = rs_ex || rs_mem || rs_wb || rt_ex || rt_mem || rt_wb;
        end
    end

    // Stall/flush decision: a busy memory stage freezes everything, then a
    // taken redirect squashes the front end, then a hazard inserts a bubble.
    always_comb begin
        freeze      = mem_busy;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        issue       = id_valid && !hz && !ex_redirect && !mem_busy;
        if (mem_busy) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (hz) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    // Slot that enters EX on the next edge: the issued instruction or a bubble.
    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid    = 1'b1;
            ex_d.dest     = id_dest;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    // Forward selects for the instruction about to enter EX, looked up
    // against the slots as they are before the shift.
    always_comb begin
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if ((FWD_EN != 0) && issue) begin
            fwd_a_d = fwd_code(rs_ex, rs_mem, rs_wb);
            fwd_b_d = fwd_code(rt_ex, rt_mem, rt_wb);
        end
    end

    // Tracking pipe advances in step with the datapath and holds while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    // Forward selects travel with the instruction into EX and hold on freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else if (!mem_busy) begin
            fwd_a_sel <= fwd_a_d;
            fwd_b_sel <= fwd_b_d;
        end
    end

    // Saturating stall counter: counts every cycle ID is held, frozen or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_id && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Saturating flush counter: counts every cycle the front end is squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (flush_if_id && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule
